// File: rtl/symm_sub_ctrl.sv
// rtl/symm_sub_ctrl.sv - round-robin burst controller sharing one subtractor between two requesters
module symm_sub_ctrl #(
    parameter int CW = 4
) (
    input  logic          clk_ctl,
    input  logic          rstn_ctl,
    input  logic          req_a,
    input  logic          req_b,
    input  logic [CW-1:0] cnt_a,
    input  logic [CW-1:0] cnt_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          en_sub,
    output logic          sel_sub,
    output logic [CW-1:0] idx_sub,
    output logic          vld_a,
    output logic          vld_b,
    output logic          done_a,
    output logic          done_b,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    state_t        state_q;
    state_t        state_n;

    // Burst context latched at the IDLE decision; sel_q = 1 means B owns the burst.
    logic          sel_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] idx_q;
    logic          last_b_q;
    logic          vld_a_q;
    logic          vld_b_q;

    logic          any_req;
    logic          win_b;
    logic          idx_last;

    assign any_req  = req_a | req_b;
    // On a tie the requester not served last wins; a lone request always wins.
    assign win_b    = (req_a & req_b) ? ~last_b_q : req_b;
    // cnt_q == 0 encodes 2^CW, so cnt_q - 1 wraps to all-ones as the final index.
    assign idx_last = (idx_q == (cnt_q - ONE));

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_ctl) begin
        if (!rstn_ctl) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state decision: IDLE arbitrates, RUN counts ops, DRAIN lasts one cycle.
    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                if (idx_last) begin
                    state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Burst context, op index, round-robin history and the one-cycle result-valid delay.
    always_ff @(posedge clk_ctl) begin
        if (!rstn_ctl) begin
            sel_q    <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= '0;
            last_b_q <= 1'b1;
            vld_a_q  <= 1'b0;
            vld_b_q  <= 1'b0;
        end else begin
            vld_a_q <= en_sub & ~sel_q;
            vld_b_q <= en_sub & sel_q;
            if (state_q == ST_IDLE) begin
                if (any_req) begin
                    sel_q    <= win_b;
                    cnt_q    <= win_b ? cnt_b : cnt_a;
                    idx_q    <= '0;
                    last_b_q <= win_b;
                end
            end else if (state_q == ST_RUN) begin
                idx_q <= idx_q + ONE;
            end
        end
    end

    // Moore outputs decoded from the registered state and the latched owner.
    always_comb begin
        gnt_a   = 1'b0;
        gnt_b   = 1'b0;
        en_sub  = 1'b0;
        sel_sub = 1'b0;
        idx_sub = '0;
        done_a  = 1'b0;
        done_b  = 1'b0;
        busy    = 1'b0;
        case (state_q)
            ST_RUN: begin
                busy    = 1'b1;
                gnt_a   = ~sel_q;
                gnt_b   = sel_q;
                sel_sub = sel_q;
                en_sub  = 1'b1;
                idx_sub = idx_q;
            end
            ST_DRAIN: begin
                busy    = 1'b1;
                gnt_a   = ~sel_q;
                gnt_b   = sel_q;
                sel_sub = sel_q;
                done_a  = ~sel_q;
                done_b  = sel_q;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign vld_a = vld_a_q;
    assign vld_b = vld_b_q;

endmodule

// File: tb/tb_symm_sub_ctrl.sv
// tb/tb_symm_sub_ctrl.sv - directed vector bench for symm_sub_ctrl
module tb_symm_sub_ctrl;

    logic       clk;
    logic       rstn;
    logic       req_a;
    logic       req_b;
    logic [3:0] cnt_a;
    logic [3:0] cnt_b;
    logic       gnt_a;
    logic       gnt_b;
    logic       en_sub;
    logic       sel_sub;
    logic [3:0] idx_sub;
    logic       vld_a;
    logic       vld_b;
    logic       done_a;
    logic       done_b;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int en_acc   = 0;
    int vld_acc  = 0;

    symm_sub_ctrl #(.CW(4)) dut (
        .clk_ctl (clk),
        .rstn_ctl(rstn),
        .req_a   (req_a),
        .req_b   (req_b),
        .cnt_a   (cnt_a),
        .cnt_b   (cnt_b),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b),
        .en_sub  (en_sub),
        .sel_sub (sel_sub),
        .idx_sub (idx_sub),
        .vld_a   (vld_a),
        .vld_b   (vld_b),
        .done_a  (done_a),
        .done_b  (done_b),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // exp = {gnt_a, gnt_b, en_sub, sel_sub, idx_sub[3:0], vld_a, vld_b, done_a, done_b, busy}
    typedef struct packed {
        logic        rstn;
        logic        ra;
        logic        rb;
        logic [3:0]  ca;
        logic [3:0]  cb;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs [22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous properties: one-hot grant, en_sub only while busy, vld count equals op count.
    always @(negedge clk) begin
        if (rstn) begin
            check("gnt_exclusive", {31'd0, gnt_a & gnt_b}, 32'd0);
            check("en_implies_busy", {31'd0, en_sub & ~busy}, 32'd0);
            if (en_sub) en_acc++;
            if (vld_a | vld_b) vld_acc++;
            if (done_a | done_b) begin
                check("vld_count_per_burst", vld_acc, en_acc);
                en_acc  = 0;
                vld_acc = 0;
            end
        end else begin
            en_acc  = 0;
            vld_acc = 0;
        end
    end

    task automatic run_burst(input logic is_b, input logic [3:0] cnt, input logic drop_early);
        int  n_exp;
        int  en_c;
        int  vld_c;
        int  done_c;
        int  busy_c;
        logic seen;
        logic ended;
        n_exp  = (cnt == 4'd0) ? 16 : int'(cnt);
        en_c   = 0;
        vld_c  = 0;
        done_c = 0;
        busy_c = 0;
        seen   = 1'b0;
        ended  = 1'b0;
        req_a  = ~is_b;
        req_b  = is_b;
        cnt_a  = cnt;
        cnt_b  = cnt;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk);
            #1;
            if (busy) begin
                seen = 1'b1;
                busy_c++;
                check("burst_owner", {29'd0, gnt_a, gnt_b, sel_sub}, is_b ? 32'd3 : 32'd4);
                if (drop_early) begin
                    req_a = 1'b0;
                    req_b = 1'b0;
                end
            end
            if (en_sub) begin
                check("burst_idx", {28'd0, idx_sub}, en_c);
                en_c++;
            end
            if (is_b ? vld_b : vld_a) vld_c++;
            if (done_a | done_b) begin
                done_c++;
                check("done_side", {30'd0, done_a, done_b}, is_b ? 32'd1 : 32'd2);
                check("done_with_vld", {31'd0, is_b ? vld_b : vld_a}, 32'd1);
            end
            if (seen && !busy) begin
                ended = 1'b1;
                break;
            end
        end
        req_a = 1'b0;
        req_b = 1'b0;
        check("burst_completes", {31'd0, ended}, 32'd1);
        check("burst_en_count", en_c, n_exp);
        check("burst_vld_count", vld_c, n_exp);
        check("burst_done_count", done_c, 32'd1);
        check("burst_busy_cycles", busy_c, n_exp + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 4'd3, 4'd0, 13'b0_0_0_0_0000_0_0_0_0_0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 4'd3, 4'd0, 13'b1_0_1_0_0000_0_0_0_0_1};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 4'd3, 4'd0, 13'b1_0_1_0_0001_1_0_0_0_1};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 4'd3, 4'd0, 13'b1_0_1_0_0010_1_0_0_0_1};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 4'd3, 4'd0, 13'b1_0_0_0_0000_1_0_1_0_1};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 4'd3, 4'd0, 13'b0_0_0_0_0000_0_0_0_0_0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 4'd2, 4'd2, 13'b0_0_0_0_0000_0_0_0_0_0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 4'd2, 4'd2, 13'b1_0_1_0_0000_0_0_0_0_1};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 4'd2, 4'd2, 13'b1_0_1_0_0001_1_0_0_0_1};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 4'd2, 4'd2, 13'b1_0_0_0_0000_1_0_1_0_1};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 4'd2, 4'd2, 13'b0_0_0_0_0000_0_0_0_0_0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 4'd2, 4'd2, 13'b0_1_1_1_0000_0_0_0_0_1};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 4'd2, 4'd2, 13'b0_1_1_1_0001_0_1_0_0_1};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 4'd2, 4'd2, 13'b0_1_0_1_0000_0_1_0_1_1};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 4'd2, 4'd2, 13'b0_0_0_0_0000_0_0_0_0_0};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 4'd2, 4'd2, 13'b1_0_1_0_0000_0_0_0_0_1};
        vecs[16] = '{1'b1, 1'b1, 1'b1, 4'd2, 4'd2, 13'b1_0_1_0_0001_1_0_0_0_1};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 4'd2, 4'd2, 13'b0_0_0_0_0000_0_0_0_0_0};
        vecs[18] = '{1'b1, 1'b0, 1'b1, 4'd2, 4'd2, 13'b0_1_1_1_0000_0_0_0_0_1};
        vecs[19] = '{1'b1, 1'b0, 1'b1, 4'd2, 4'd2, 13'b0_1_1_1_0001_0_1_0_0_1};
        vecs[20] = '{1'b1, 1'b0, 1'b1, 4'd2, 4'd2, 13'b0_1_0_1_0000_0_1_0_1_1};
        vecs[21] = '{1'b1, 1'b0, 1'b0, 4'd2, 4'd2, 13'b0_0_0_0_0000_0_0_0_0_0};

        rstn  = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        cnt_a = 4'd0;
        cnt_b = 4'd0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 22; i++) begin
            rstn  = vecs[i].rstn;
            req_a = vecs[i].ra;
            req_b = vecs[i].rb;
            cnt_a = vecs[i].ca;
            cnt_b = vecs[i].cb;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i),
                  {19'd0, gnt_a, gnt_b, en_sub, sel_sub, idx_sub, vld_a, vld_b, done_a, done_b, busy},
                  {19'd0, vecs[i].exp});
        end

        run_burst(1'b1, 4'd0, 1'b0);
        run_burst(1'b0, 4'd5, 1'b1);
        run_burst(1'b0, 4'd1, 1'b0);
        run_burst(1'b1, 4'd15, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check("idle_after_tests", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/symm_sub_ctrl.md
SYMM_SUB_CTRL -- requirements
Module: symm_sub_ctrl

Interface
REQ-001 SHALL have parameter CW, default 4, meaning the width of the burst-length and index fields.
REQ-002 SHALL have port clk_ctl, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn_ctl, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have ports req_a and req_b, inputs, 1 bit each: the requester A and requester B burst requests, level.
REQ-005 SHALL have ports cnt_a and cnt_b, inputs, CW bits each: the burst length per requester; 0 encodes 2^CW.
REQ-006 SHALL have ports gnt_a and gnt_b, outputs, 1 bit each: the grant, held for the whole burst.
REQ-007 SHALL have port en_sub, output, 1 bit: the enable to the shared 4x4 subtractor, one op per cycle.
REQ-008 SHALL have port sel_sub, output, 1 bit: the operand-mux select, 0 = A and 1 = B; valid whenever gnt_a or gnt_b is high.
REQ-009 SHALL have port idx_sub, output, CW bits: the index of the current op within the burst, for external operand addressing.
REQ-010 SHALL have ports vld_a and vld_b, outputs, 1 bit each: a one-cycle pulse meaning the subtractor output holds a fresh result for that requester.
REQ-011 SHALL have ports done_a and done_b, outputs, 1 bit each: a one-cycle pulse coincident with the last vld of the burst.
REQ-012 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and DRAIN, all registered.
REQ-014 SHALL, in IDLE, sample req_a, req_b, cnt_a and cnt_b.
- If any request is high, the FSM latches the winner, its count N and the select, then moves to RUN next cycle.
- If no request is high, the FSM stays in IDLE.
REQ-015 SHALL arbitrate round-robin: when both requests are high, grant the requester not served last; a single request is granted regardless of history.
REQ-016 SHALL, in RUN, hold the winner's gnt_x, drive en_sub=1 every cycle, and step idx_sub 0,1,...,N-1, one value per cycle.
REQ-017 SHALL move RUN->DRAIN in the cycle after idx_sub==N-1, wrapping at 2^CW-1 when N=2^CW.
REQ-018 SHALL, in DRAIN, drive en_sub=0, keep gnt_x and sel_sub held, pulse done_x, then return to IDLE.
REQ-019 SHALL drive vld_x as en_sub delayed by one cycle and qualified by the latched select (subtractor latency = 1 cycle).
- vld_x is high exactly N cycles per burst.
- The last vld_x pulse falls in DRAIN.
REQ-020 SHALL ignore req and cnt changes outside IDLE: a deasserted request does not abort a burst, and an asserted one waits.
REQ-021 SHALL never assert gnt_a and gnt_b together, and never assert en_sub outside RUN.
REQ-022 SHALL give each burst of length N a total occupancy of N+2 cycles: 1 IDLE decision, N RUN and 1 DRAIN.
REQ-023 SHALL serve back-to-back requests with exactly one IDLE cycle between DRAIN and the next RUN.
REQ-024 SHALL update the last-served record on entry to RUN.

Reset
REQ-025 SHALL, when rstn_ctl=0 at a clock edge, set state to IDLE and last-served to B, so that A wins the first tie.
REQ-026 SHALL, under reset, drive gnt_a, gnt_b, en_sub, sel_sub, idx_sub, vld_a, vld_b, done_a, done_b and busy all to 0.
REQ-027 SHALL, on reset mid-burst, abort the burst at that edge with no done pulse and no further en_sub; the subtractor's registered outputs are not cleared by this block.
REQ-028 SHALL resume arbitration from IDLE on the first edge with rstn_ctl=1.

Verification
REQ-029 SHALL be verified with single A with cnt_a=3 -> gnt_a for 4 cycles, en_sub 3 cycles with idx 0,1,2, vld_a 3 cycles lagging by 1, done_a with the 3rd vld, busy 4 cycles.
REQ-030 SHALL be verified with req_a and req_b both held high after reset, cnt=2 each -> grants alternate A,B,A,B; each burst lasts 4 cycles with 1 IDLE cycle between; sel_sub=0 during A and 1 during B.
REQ-031 SHALL be verified with cnt_b=0 -> 16 en_sub cycles, idx_sub 0..15, exactly 16 vld_b pulses, 1 done_b.
REQ-032 SHALL be verified with req_a dropped after the first RUN cycle, cnt_a=5 -> the burst still completes all 5 ops and done_a fires.
REQ-033 SHALL be verified with rstn_ctl=0 at RUN idx=1 -> at the next edge all outputs are 0, with no done_a pulse; after release, a pending req_b is granted after 1 IDLE cycle.
REQ-034 SHALL be checked continuously by assertions: gnt_a&gnt_b never high; en_sub implies busy; count of vld_x equals N per burst.
